// File: rtl/if_fetch_bridge_pkg.sv
// Shared definitions for the instruction/data SRAM-like bus bridges.
// Holds the fetch FSM state encoding, the kseg0/kseg1 address constants
// and a small alignment helper used on the fetch side.
package if_fetch_bridge_pkg;

  // Fetch FSM states: idle, address presented, waiting data,
  // word held for a stalled pipe, and draining a voided fetch.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

  // Top two virtual address bits selecting the unmapped kseg0/kseg1 window.
  localparam logic [1:0]  KSEG01_SEG = 2'b10;
  // Upper physical bits forced for kseg0/kseg1 (512 MB physical window).
  localparam logic [2:0]  PHYS_TOP   = 3'b000;
  localparam logic [31:0] WORD_ZERO  = 32'h0000_0000;

  // A fetch PC is usable only on a word boundary.
  function automatic logic is_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_bridge_if.sv
// SRAM-like instruction bus bundle between the fetch bridge and memory.
// Latency: none (wires only).
// Backpressure: the slave holds off a request by keeping inst_addr_ok low.
interface if_fetch_bridge_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // Bridge side: drives the request, receives handshakes and data.
  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  // Memory side: observes the request, answers with handshakes and data.
  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_bridge_addr_map.sv
// Virtual-to-physical mapping for the unmapped kernel segments.
// Latency: combinational.
// Backpressure: none.
module addr_map
  import if_fetch_bridge_pkg::*;
(
  input  logic [31:0] i_vaddr,
  output logic [31:0] o_paddr
);

  // kseg0 and kseg1 alias the same low 512 MB; everything else passes through.
  assign o_paddr = (i_vaddr[31:30] == KSEG01_SEG) ? {PHYS_TOP, i_vaddr[28:0]}
                                                  : i_vaddr;

endmodule

// File: rtl/if_fetch_bridge.sv
// Bridge between the IF stage fetch ports and the SRAM-like instruction bus.
// Latency: zero-wait bus delivers in the request cycle; otherwise data_ok cycle.
// Backpressure: stallreq_from_if until the word arrives; HOLD buffers it while pipe_stall.
module if_fetch_bridge
  import if_fetch_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        fetch_en,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic [31:0] if_instr,
  output logic        stallreq_from_if,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [15:0] ok_count
);

  fetch_state_e r_state;
  logic [31:0]  r_addr;      // address held stable while waiting addr_ok
  logic [31:0]  r_buf;       // word kept for a stalled pipeline
  logic         r_discard;   // flush seen while the address was still pending
  logic [15:0]  r_ok_count;

  logic         w_aligned;
  logic         w_want;
  logic [31:0]  w_paddr;
  logic         w_issue;
  logic         w_req;
  logic         w_deliver;

  addr_map u_addr_map (
    .i_vaddr (if_pc),
    .o_paddr (w_paddr)
  );

  assign w_aligned = is_aligned(if_pc);
  assign w_want    = fetch_en & w_aligned & ~flush;

  // Decide whether a fresh request goes out and whether a word is delivered now.
  always_comb begin
    w_issue   = 1'b0;
    w_deliver = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_issue   = w_want;
        w_deliver = w_want & inst_addr_ok & inst_data_ok;
      end
      ST_ADDR: begin
        w_deliver = inst_addr_ok & inst_data_ok & ~r_discard & ~flush;
      end
      ST_DATA: begin
        w_deliver = inst_data_ok & ~flush;
      end
      ST_DROP: begin
        // Only one fetch may be outstanding: wait for the voided word first.
        w_issue   = w_want & inst_data_ok;
      end
      default: begin
        w_issue   = 1'b0;
        w_deliver = 1'b0;
      end
    endcase
  end

  assign w_req = (r_state == ST_ADDR) | w_issue;

  // Reset forces every fetch-side output low immediately, not just at the next edge.
  assign inst_req         = rst & w_req;
  assign inst_addr        = !rst ? WORD_ZERO
                          : (r_state == ST_ADDR) ? r_addr : w_paddr;
  assign if_instr         = !rst ? WORD_ZERO
                          : w_deliver ? inst_rdata
                          : (r_state == ST_HOLD) ? r_buf : WORD_ZERO;
  assign stallreq_from_if = rst & fetch_en & w_aligned & ~w_deliver
                          & (r_state != ST_HOLD);
  assign ok_count         = r_ok_count;

  // Fetch FSM: request tracking, flush voiding, stall buffering and delivery count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= WORD_ZERO;
      r_buf      <= WORD_ZERO;
      r_discard  <= 1'b0;
      r_ok_count <= 16'h0000;
    end else begin
      if (w_deliver) begin
        r_ok_count <= r_ok_count + 16'd1;
      end
      if (w_deliver && pipe_stall) begin
        r_buf <= inst_rdata;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            if (!inst_addr_ok) begin
              r_state <= ST_ADDR;
              r_addr  <= w_paddr;
            end else if (inst_data_ok) begin
              r_state <= pipe_stall ? ST_HOLD : ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end

        ST_ADDR: begin
          if (inst_addr_ok) begin
            r_discard <= 1'b0;
            if (inst_data_ok) begin
              r_state <= (w_deliver && pipe_stall) ? ST_HOLD : ST_IDLE;
            end else begin
              r_state <= (r_discard || flush) ? ST_DROP : ST_DATA;
            end
          end else if (flush) begin
            // The request cannot be withdrawn; remember to throw its data away.
            r_discard <= 1'b1;
          end
        end

        ST_DATA: begin
          if (inst_data_ok) begin
            r_state <= (w_deliver && pipe_stall) ? ST_HOLD : ST_IDLE;
          end else if (flush) begin
            r_state <= ST_DROP;
          end
        end

        ST_HOLD: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_buf   <= WORD_ZERO;
          end else if (!pipe_stall) begin
            r_state <= ST_IDLE;
          end
        end

        ST_DROP: begin
          if (inst_data_ok) begin
            if (w_issue) begin
              if (!inst_addr_ok) begin
                r_state <= ST_ADDR;
                r_addr  <= w_paddr;
              end else begin
                // This cycle's data_ok belongs to the voided fetch.
                r_state <= ST_DATA;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_bridge.md
IF_FETCH_BRIDGE -- requirements
Module: if_fetch_bridge

Interface
REQ-001 The port list SHALL be, in this order (name  direction  width  meaning): clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 if_pc  in  32  fetch PC from the IF stage.
REQ-004 fetch_en  in  1  IF wants the instruction at if_pc this cycle.
REQ-005 pipe_stall  in  1  hazard-unit stall of IF/ID; the delivered instruction must be held.
REQ-006 flush  in  1  exception/eret redirect; the outstanding fetch is void.
REQ-007 if_instr  out  32  instruction delivered to the if2id register.
REQ-008 stallreq_from_if  out  1  fetch not complete; hazard unit stalls the pipeline.
REQ-009 inst_req  out  1  bus request.
REQ-010 inst_addr  out  32  physical fetch address.
REQ-011 inst_addr_ok  in  1  bus accepted the address.
REQ-012 inst_data_ok  in  1  bus returns read data.
REQ-013 inst_rdata  in  32  bus read data.
REQ-014 ok_count  out  16  count of completed (non-discarded) fetches.

Function
REQ-015 The block SHALL have exactly these states: IDLE, ADDR (request presented, waiting addr_ok), DATA (waiting data_ok), HOLD (word buffered, pipeline stalled), DROP (waiting data_ok of a flushed fetch).
REQ-016 inst_req SHALL be 1 in ADDR, and in IDLE/DROP when fetch_en=1, flush=0 and if_pc[1:0]=0; otherwise 0.
REQ-017 Once asserted, inst_req and inst_addr SHALL remain stable until inst_addr_ok=1, even if flush arrives.
REQ-018 Physical address: if_pc[31:30]=2'b10 (kseg0/kseg1) -> {3'b000, if_pc[28:0]}; otherwise if_pc unchanged.
REQ-019 Transitions: request without addr_ok -> ADDR; addr_ok -> DATA; in DATA, data_ok with pipe_stall=1 -> HOLD (buffer inst_rdata); data_ok with pipe_stall=0 -> IDLE.
REQ-020 Accepted request with inst_addr_ok and inst_data_ok both 1 in the same cycle SHALL complete in that cycle (zero-wait bus).
REQ-021 if_instr SHALL be inst_rdata in the data_ok cycle, the buffer in HOLD, otherwise 32'h0.
REQ-022 stallreq_from_if SHALL be 1 when fetch_en=1 and aligned, except in the data_ok completion cycle and in HOLD.
REQ-023 HOLD SHALL persist while pipe_stall=1, and SHALL exit to IDLE on the first cycle with pipe_stall=0.
REQ-024 flush in ADDR sets a discard flag; on addr_ok -> DROP. flush in DATA -> DROP. flush in HOLD -> IDLE with buffer invalidated.
REQ-025 In DROP, data_ok SHALL NOT drive if_instr and SHALL NOT increment ok_count; the next state is IDLE, or ADDR/DATA if the same-cycle new request is issued.
REQ-026 Misaligned if_pc with fetch_en=1: no bus request, stallreq_from_if=0, if_instr=0; the IF stage raises the exception.
REQ-027 Only one outstanding fetch SHALL exist; a new request issues only from IDLE or from DROP in its data_ok cycle.
REQ-028 ok_count SHALL increment by 1 per delivered word and wrap from 16'hFFFF to 0.

Reset
REQ-029 While rst=0: state=IDLE, buffer=0, discard flag=0, ok_count=0, inst_req=0, stallreq_from_if=0, if_instr=0.
REQ-030 Reset asserted mid-fetch SHALL abandon the transaction; a late data_ok after reset is ignored in IDLE.

Structure
REQ-031 State encodings and the kseg address constants SHALL reside in the shared defines header.
REQ-032 The address-mapping function SHALL be a sub-module, addr_map, shared with the future data-side bridge.
REQ-033 The block SHALL sit between the datapath fetch ports (if_pc, if_instr, stallreq_from_if) and the instruction SRAM-like bus.

Verification
REQ-034 The bench SHALL cover: if_pc=32'hBFC0_0000, addr_ok and data_ok in the same cycle, rdata=32'h2408_0001 -> inst_addr=32'h1FC0_0000; if_instr valid that cycle; stall never asserted; ok_count=1.
REQ-035 The bench SHALL cover: addr_ok delayed 3 cycles, data_ok 2 cycles later -> inst_req stable 4 cycles; stallreq_from_if high until the data_ok cycle.
REQ-036 The bench SHALL cover: data_ok with pipe_stall=1 for 3 cycles -> if_instr held at buffered word; stallreq_from_if=0; IDLE after release.
REQ-037 The bench SHALL cover: flush in DATA, then data_ok rdata=32'hDEAD_BEEF -> if_instr=0 that cycle; ok_count unchanged; new PC 32'hBFC0_0380 fetched next.
REQ-038 The bench SHALL cover: if_pc=32'hBFC0_0002 with fetch_en -> inst_req=0 and stallreq_from_if=0.
REQ-039 The bench SHALL cover: rst=0 during ADDR -> all outputs zero asynchronously; after release, a stray data_ok is ignored.
